// File: rtl/bcd_scan_counter_pkg.sv
// Shared BCD types and constants for the scanned BCD counter.
package bcd_scan_counter_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_BLANK = 4'hF;
   localparam bcd_t BCD_MAX   = 4'd9;

   function automatic logic is_bcd(input bcd_t d);
      return d <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD up/down digit cell: step in from the lower digit,
// step out (carry or borrow) to the next higher digit.
module bcd_digit
   import bcd_scan_counter_pkg::*;
(
   input  logic up_dn,
   input  logic step_in,
   input  bcd_t digit,
   output bcd_t digit_next,
   output logic step_out
);

   always_comb begin
      digit_next = digit;
      step_out   = 1'b0;
      if (step_in) begin
         if (up_dn) begin
            if (digit >= BCD_MAX) begin
               digit_next = '0;
               step_out   = 1'b1;
            end else begin
               digit_next = digit + 4'd1;
            end
         end else begin
            if (digit == '0) begin
               digit_next = BCD_MAX;
               step_out   = 1'b1;
            end else begin
               digit_next = digit - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed
// digit scanner feeding a seven-segment decoder.
module bcd_scan_counter
   import bcd_scan_counter_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int BLANK_LZ   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    up_dn,
   input  logic                    clr,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   output logic [4*NUM_DIGITS-1:0] count_val,
   output logic                    carry,
   output logic                    load_err,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   dig_sel
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [NUM_DIGITS:0]   step;
   logic [W-1:0]          count_next;
   logic                  load_ok;
   logic [NUM_DIGITS-1:0] blank;
   logic                  hi_zero;
   logic [PW-1:0]         presc;
   logic                  tc;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_next;
   bcd_t                  nib_next;

   assign step[0] = en;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      bcd_digit u_digit (
         .up_dn      (up_dn),
         .step_in    (step[i]),
         .digit      (count_val[4*i +: 4]),
         .digit_next (count_next[4*i +: 4]),
         .step_out   (step[i+1])
      );
   end

   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!is_bcd(load_val[4*i +: 4])) load_ok = 1'b0;
      end
   end

   // Invalid loads leave the count alone so no non-BCD state exists
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_val <= '0;
         carry     <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         carry    <= 1'b0;
         load_err <= 1'b0;
         if (clr) begin
            count_val <= '0;
         end else if (load) begin
            if (load_ok) count_val <= load_val;
            else         load_err  <= 1'b1;
         end else if (en) begin
            count_val <= count_next;
            carry     <= step[NUM_DIGITS];
         end
      end
   end

   // Digit k blanks when it and all higher digits are zero
   always_comb begin
      blank   = '0;
      hi_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         hi_zero  = hi_zero && (count_val[4*i +: 4] == 4'd0);
         blank[i] = (BLANK_LZ != 0) && hi_zero;
      end
   end

   assign tc = (presc == PRESC_TC);

   always_comb begin
      idx_next = idx;
      if (tc) idx_next = (idx == IDX_LAST) ? '0 : idx + IW'(1);
   end

   always_comb begin
      nib_next = count_val[4*int'(idx_next) +: 4];
      if (blank[idx_next]) nib_next = BCD_BLANK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc   <= '0;
         idx     <= '0;
         dig_sel <= NUM_DIGITS'(1);
         bcd_out <= '0;
      end else begin
         presc   <= tc ? '0 : presc + PW'(1);
         idx     <= idx_next;
         dig_sel <= NUM_DIGITS'(1) << idx_next;
         bcd_out <= nib_next;
      end
   end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
Multi-digit BCD up/down counter with a time-multiplexed display scanner. It sits directly upstream of the BCD-to-seven-segment decoder. Each scan slot presents one digit's BCD nibble on bcd_out, which drives the decoder's D input, plus a one-hot digit strobe for the common anodes/cathodes. Blanked digits are driven as 4'hF, which the decoder renders as all segments off.

Parameters:
NUM_DIGITS, 4, number of BCD digits counted and scanned (1..8)
SCAN_DIV, 1000, clk cycles each digit stays selected (>=2)
BLANK_LZ, 1, 1 = blank leading zero digits; digit 0 is never blanked

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  count enable; one step per cycle while high
up_dn  input  1  1 = count up, 0 = count down
clr  input  1  synchronous clear to zero
load  input  1  synchronous load of load_val
load_val  input  4*NUM_DIGITS  BCD load value; digit 0 in [3:0]
count_val  output  4*NUM_DIGITS  current count, registered BCD
carry  output  1  one-cycle pulse on wrap (up: all 9s -> 0; down: 0 -> all 9s)
load_err  output  1  one-cycle pulse when a load is rejected
bcd_out  output  4  selected digit's nibble to the decoder; 4'hF = blank
dig_sel  output  NUM_DIGITS  one-hot digit strobe, active high

Behaviour:
- Reset (async assert, sync release): count_val=0, carry=0, load_err=0, scan index=0, prescaler=0, dig_sel=1 (digit 0), bcd_out=4'h0.
- Command priority per cycle: clr > load > en. Lower-priority inputs are ignored that cycle.
- clr: count_val=0 next cycle; carry=0.
- load: if every nibble of load_val is <=9, count_val=load_val next cycle. Otherwise count_val is unchanged and load_err pulses next cycle. A load never produces carry.
- en, up: add 1 to digit 0 and ripple. A digit at 9 becomes 0 and increments the next digit. If all digits are 9, the result is all 0 and carry=1 next cycle.
- en, down: subtract 1 from digit 0 and ripple. A digit at 0 becomes 9 and borrows from the next digit. If all digits are 0, the result is all 9 and carry=1 next cycle.
- Count latency: count_val reflects a command one cycle after it is sampled. carry is high only in the cycle count_val shows the wrapped value.
- Each digit is always 0..9. No invalid BCD state is reachable.
- Prescaler: counts 0..SCAN_DIV-1 and is free-running; it ignores en, clr and load. On the terminal count, the scan index advances, wrapping from NUM_DIGITS-1 to 0.
- dig_sel = one-hot(scan index), registered. It changes in the cycle after the prescaler's terminal count. Exactly one bit is high at all times after reset.
- bcd_out is registered and always updated in the same cycle as dig_sel. Its value is the nibble of count_val at the selected index, or 4'hF if blanked.
- bcd_out follows count changes within the current slot with one cycle of latency.
- Leading-zero blanking (BLANK_LZ=1): digit k>0 is blanked when it and every higher digit are 0. Example: count 0040 displays " 40". Count 0 shows "0" on digit 0 only.
- Reset mid-scan or mid-count: everything returns to reset values immediately, with no partial ripple.
- en held with up_dn toggling: each cycle uses that cycle's up_dn value.

Decomposition:
- Shared package: BCD digit typedef (4-bit), constant BCD_BLANK=4'hF, constant BCD_MAX=4'd9.
- One natural sub-module, bcd_digit: a single-digit BCD up/down cell with carry/borrow in and out. Instantiate it NUM_DIGITS times in a ripple chain.
- Prescaler, scan index, blanking and output mux live in the top level.

Test Plan:
- Reset, then wait 4*SCAN_DIV cycles with en=0 -> dig_sel cycles 0001, 0010, 0100, 1000, 0001. bcd_out=0 for digit 0 and F for the others. count_val=0.
- Load 0x0999, then one up step -> count_val=0x1000, carry=0. Load 0x9999, then one up step -> count_val=0x0000, carry pulses for exactly 1 cycle.
- From 0x0000, one down step -> count_val=0x9999 with a carry pulse. A second down step -> 0x9998.
- Load 0x12A4 -> load_err pulses once and count_val is unchanged. Assert clr, load and en together -> count_val=0.
- Count 0x0040 scanned -> bcd_out sequence 0, 4, F, F aligned with dig_sel. With BLANK_LZ=0 -> 0, 4, 0, 0.
- Assert rst asynchronously mid-slot and mid-count -> all outputs take reset values before the next clk edge. Scanning restarts at digit 0.
